// File: rtl/sum_of_sqr_fp32.sv
// Two-stage fp32 c = a^2 + b^2: stage 1 squares and rounds each operand to fp32,
// stage 2 adds the two non-negative squares. Round-to-nearest-even, subnormals flushed.
module sum_of_sqr_fp32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] c_out
);

  localparam int unsigned DATA_W = 32;
  localparam logic [30:0] PINF   = 31'h7F800000;
  localparam logic [30:0] QNAN   = 31'h7FC00000;

  // Squares are non-negative, so operand signs never reach the datapath.
  logic sign_unused;
  assign sign_unused = a_in[31] ^ b_in[31];

  // Rounds a normalised significand (implicit 1 dropped) with RNE and packs it.
  function automatic logic [30:0] round_pack(input logic signed [10:0] ex_in,
                                             input logic [22:0] frac,
                                             input logic g,
                                             input logic s);
    logic signed [10:0] ex;
    logic        [23:0] f;
    f  = {1'b0, frac} + {23'd0, (g & (s | frac[0]))};
    ex = ex_in + $signed({10'd0, f[23]});
    if (ex >= 11'sd255)
      return PINF;
    else if (ex < 11'sd1)
      return 31'd0;
    else
      return {ex[7:0], f[22:0]};
  endfunction

  function automatic logic [30:0] fp_square(input logic [30:0] x);
    logic        [47:0] m;
    logic        [47:0] p;
    logic signed [10:0] ex;
    if (x[30:23] == 8'hFF)
      return (x[22:0] != 23'd0) ? QNAN : PINF;
    if (x[30:23] == 8'h00)
      return 31'd0;
    m  = {24'd0, 1'b1, x[22:0]};
    p  = m * m;
    ex = $signed({2'b00, x[30:23], 1'b0}) - 11'sd127;
    if (p[47])
      return round_pack(ex + 11'sd1, p[46:24], p[23], |p[22:0]);
    else
      return round_pack(ex, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [30:0] fp_add_pos(input logic [30:0] x, input logic [30:0] y);
    logic [30:0] big;
    logic [30:0] sml;
    logic [7:0]  d;
    logic [49:0] sh;
    logic [26:0] al;
    logic [27:0] sum;
    logic signed [10:0] ex;
    if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
      return QNAN;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
      return PINF;
    if (x[30:23] == 8'h00)
      return y;
    if (y[30:23] == 8'h00)
      return x;
    if (y[30:23] > x[30:23]) begin
      big = y;
      sml = x;
    end else begin
      big = x;
      sml = y;
    end
    d = big[30:23] - sml[30:23];
    // Aligned smaller significand carries guard, round and a sticky OR in its low 3 bits.
    if (d >= 8'd26) begin
      al = 27'd1;
    end else begin
      sh = {1'b1, sml[22:0], 26'd0} >> d;
      al = {sh[49:24], |sh[23:0]};
    end
    sum = {1'b0, 1'b1, big[22:0], 3'b000} + {1'b0, al};
    ex  = $signed({3'b000, big[30:23]});
    if (sum[27])
      return round_pack(ex + 11'sd1, sum[26:4], sum[3], |sum[2:0]);
    else
      return round_pack(ex, sum[25:3], sum[2], |sum[1:0]);
  endfunction

  logic [30:0]       sa_p1_d, sb_p1_d;
  logic [30:0]       sa_p1_q, sb_p1_q;
  logic [DATA_W-1:0] c_p2_d, c_p2_q;

  always_comb begin
    sa_p1_d = fp_square(a_in[30:0]);
    sb_p1_d = fp_square(b_in[30:0]);
    c_p2_d  = {1'b0, fp_add_pos(sa_p1_q, sb_p1_q)};
  end

  // Stage 1 boundary: registered squares. Stage 2 boundary: registered sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_p1_q <= 31'd0;
      sb_p1_q <= 31'd0;
      c_p2_q  <= '0;
    end else begin
      sa_p1_q <= sa_p1_d;
      sb_p1_q <= sb_p1_d;
      c_p2_q  <= c_p2_d;
    end
  end

  assign c_out = c_p2_q;

endmodule

// File: tb/tb_sum_of_sqr_fp32.sv
// Directed bench for sum_of_sqr_fp32: driver queues hand-computed results,
// a monitor pops and compares them as each result leaves the pipeline.
module tb_sum_of_sqr_fp32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, c;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        iss = 1'b0;
  logic        v1, v2;

  always #5 clk = ~clk;

  sum_of_sqr_fp32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_in  (a),
    .b_in  (b),
    .c_out (c)
  );

  // Two-deep shadow of "a vector was sampled" matching the pipeline depth.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= iss;
      v2 <= v1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && v2 === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %08h with no expected value queued", c);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (c !== e) begin
          n_err++;
          $display("FAIL %s: c_out=%08h expected %08h", nm, c, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: c_out=%08h expected %08h", nm, act, ex);
    end
  endtask

  task automatic apply(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input string nm);
    a   = av;
    b   = bv;
    iss = 1'b1;
    exp_q.push_back(ev);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    iss = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    a     = 32'h0;
    b     = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", c, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_held", c, 32'h0);
    rst_n = 1'b1;

    apply(32'h40800000, 32'h40000000, 32'h41A00000, "basic_4_2");
    apply(32'h41200000, 32'hC0000000, 32'h42D00000, "neg_operand");
    apply(32'h40E00000, 32'h40000000, 32'h42540000, "stream_53");
    apply(32'h40E00000, 32'h40400000, 32'h42680000, "stream_58");
    apply(32'h41200000, 32'h40800000, 32'h42E80000, "stream_116");
    apply(32'h40400000, 32'h40800000, 32'h41C80000, "three_four");
    apply(32'h3F000000, 32'h3F000000, 32'h3F000000, "half_half");
    apply(32'hBF800000, 32'h00000000, 32'h3F800000, "zero_plus_x");
    apply(32'h3F800001, 32'h00000000, 32'h3F800002, "rnd_sq_down");
    apply(32'h3F800001, 32'h3F800001, 32'h40000002, "rnd_sum_carry");
    apply(32'h3F800801, 32'h00000000, 32'h3F801003, "rnd_sq_up");
    apply(32'h3F800800, 32'h00000000, 32'h3F801000, "rnd_sq_tie_even");
    apply(32'h3F800801, 32'h39800000, 32'h3F801004, "rnd_add_tie_up");
    apply(32'h3F800000, 32'h39800000, 32'h3F800000, "rnd_add_tie_even");
    apply(32'h3F800000, 32'h35800000, 32'h3F800000, "align_sticky_only");
    apply(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_input");
    apply(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_input");
    apply(32'h7F800000, 32'h7F800001, 32'h7FC00000, "nan_over_inf");
    apply(32'h5F800000, 32'h00000000, 32'h7F800000, "square_overflow");
    apply(32'h5F7FFFFF, 32'h5F7FFFFF, 32'h7F800000, "sum_overflow");
    apply(32'h00000001, 32'h80000000, 32'h00000000, "subnormal_negzero");
    apply(32'h1F800000, 32'h00000000, 32'h00000000, "square_underflow");
    idle(4);

    // Mid-cycle asynchronous reset with a=4.0, b=2.0 held on the inputs.
    a = 32'h40800000;
    b = 32'h40000000;
    @(posedge clk);
    @(posedge clk);
    #2 chk("pre_reset_value", c, 32'h41A00000);
    #1 rst_n = 1'b0;
    #1 chk("reset_clears_async", c, 32'h0);
    exp_q.delete();
    nm_q.delete();
    @(posedge clk);
    #1 chk("reset_held_over_edge", c, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    iss   = 1'b1;
    exp_q.push_back(32'h41A00000);
    nm_q.push_back("after_reset_release");
    @(posedge clk);
    #1 chk("release_edge1_zero", c, 32'h0);
    @(negedge clk);
    iss = 1'b0;
    idle(4);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never appeared, expected 0 pending", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
